unidad_acceso_memoria: RTL and testbench

Load/store unit in the MEM stage. It sits between the pipeline and the word-addressed `memoria_datos` and drives that memory as its initiator. It converts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word reads and writes. Sub-word stores use read-modify-write, and misaligned accesses are flagged without touching memory.

---
 rtl/unidad_acceso_memoria.sv | 148 ++++++++++++++
 tb/tb_unidad_acceso_memoria.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_acceso_memoria.sv
// Load/store unit: turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses on memoria_datos.
// Sub-word stores use read-modify-write; misaligned requests finish in one cycle without touching memory.
module unidad_acceso_memoria (
    input  logic        clk,
    input  logic        reset,
    input  logic        valido,
    output logic        listo,
    input  logic        es_escritura,
    input  logic [1:0]  tamano,
    input  logic        sin_signo,
    input  logic [31:0] direccion_byte,
    input  logic [31:0] dato_in,
    output logic        hecho,
    output logic        error_alineacion,
    output logic [31:0] dato_cargado,
    output logic        mem_leer,
    output logic        mem_escribir,
    output logic [31:0] direccion,
    output logic [31:0] dato_escribir,
    input  logic [31:0] dato_leer
);

    typedef enum logic [1:0] {IDLE, LEER, ESCRIBIR, FIN} estado_t;

    localparam logic [1:0] T_BYTE = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_WORD = 2'b10;

    estado_t     estado_q, estado_d;
    logic        escr_q, escr_d;
    logic [1:0]  tam_q, tam_d;
    logic        sin_q, sin_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] dato_q, dato_d;
    logic        err_q, err_d;
    logic [31:0] palabra_q, palabra_d;

    logic        misalineado;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] mezcla;
    logic [31:0] carga;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= IDLE;
            escr_q    <= 1'b0;
            tam_q     <= 2'b00;
            sin_q     <= 1'b0;
            dir_q     <= 32'h0;
            dato_q    <= 32'h0;
            err_q     <= 1'b0;
            palabra_q <= 32'h0;
        end else begin
            estado_q  <= estado_d;
            escr_q    <= escr_d;
            tam_q     <= tam_d;
            sin_q     <= sin_d;
            dir_q     <= dir_d;
            dato_q    <= dato_d;
            err_q     <= err_d;
            palabra_q <= palabra_d;
        end
    end

    always_comb begin
        misalineado = (tamano == 2'b11)
                   || (tamano == T_HALF && direccion_byte[0])
                   || (tamano == T_WORD && direccion_byte[1:0] != 2'b00);

        // Lane selection works on the captured request and the registered word.
        off      = dir_q[1:0];
        byte_sel = palabra_q[{off, 3'b000} +: 8];
        half_sel = palabra_q[{off[1], 4'b0000} +: 16];

        mezcla = palabra_q;
        if (tam_q == T_BYTE)
            mezcla[{off, 3'b000} +: 8] = dato_q[7:0];
        else if (tam_q == T_HALF)
            mezcla[{off[1], 4'b0000} +: 16] = dato_q[15:0];

        case (tam_q)
            T_BYTE:  carga = sin_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            T_HALF:  carga = sin_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: carga = palabra_q;
        endcase
    end

    always_comb begin
        estado_d         = estado_q;
        escr_d           = escr_q;
        tam_d            = tam_q;
        sin_d            = sin_q;
        dir_d            = dir_q;
        dato_d           = dato_q;
        err_d            = err_q;
        palabra_d        = palabra_q;
        listo            = 1'b0;
        hecho            = 1'b0;
        error_alineacion = 1'b0;
        dato_cargado     = 32'h0;
        mem_leer         = 1'b0;
        mem_escribir     = 1'b0;
        direccion        = 32'h0;
        dato_escribir    = 32'h0;

        case (estado_q)
            IDLE: begin
                listo = 1'b1;
                if (valido) begin
                    escr_d = es_escritura;
                    tam_d  = tamano;
                    sin_d  = sin_signo;
                    dir_d  = direccion_byte;
                    dato_d = dato_in;
                    err_d  = misalineado;
                    if (misalineado)
                        estado_d = FIN;
                    else if (es_escritura && tamano == T_WORD)
                        estado_d = ESCRIBIR;
                    else
                        estado_d = LEER;
                end
            end
            LEER: begin
                mem_leer  = 1'b1;
                direccion = {2'b00, dir_q[31:2]};
                palabra_d = dato_leer;
                estado_d  = escr_q ? ESCRIBIR : FIN;
            end
            ESCRIBIR: begin
                mem_escribir  = 1'b1;
                direccion     = {2'b00, dir_q[31:2]};
                dato_escribir = (tam_q == T_WORD) ? dato_q : mezcla;
                estado_d      = FIN;
            end
            FIN: begin
                hecho            = 1'b1;
                error_alineacion = err_q;
                dato_cargado     = (escr_q || err_q) ? 32'h0 : carga;
                estado_d         = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// Directed bench for unidad_acceso_memoria with a 256-word memory model attached.
module tb_unidad_acceso_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        valido;
    logic        listo;
    logic        es_escritura;
    logic [1:0]  tamano;
    logic        sin_signo;
    logic [31:0] direccion_byte;
    logic [31:0] dato_in;
    logic        hecho;
    logic        error_alineacion;
    logic [31:0] dato_cargado;
    logic        mem_leer;
    logic        mem_escribir;
    logic [31:0] direccion;
    logic [31:0] dato_escribir;
    logic [31:0] dato_leer;

    logic [31:0] mem [0:255];
    logic        precarga;

    int n_comp = 0;
    int n_fail = 0;

    int          r_hecho_k, r_leer_k, r_escr_k, r_nleer, r_nescr;
    logic [31:0] r_dato, r_escr_dir, r_escr_dato;
    logic        r_err;

    always #5 clk = ~clk;

    unidad_acceso_memoria dut (
        .clk(clk), .reset(reset), .valido(valido), .listo(listo),
        .es_escritura(es_escritura), .tamano(tamano), .sin_signo(sin_signo),
        .direccion_byte(direccion_byte), .dato_in(dato_in), .hecho(hecho),
        .error_alineacion(error_alineacion), .dato_cargado(dato_cargado),
        .mem_leer(mem_leer), .mem_escribir(mem_escribir), .direccion(direccion),
        .dato_escribir(dato_escribir), .dato_leer(dato_leer)
    );

    assign dato_leer = mem[direccion[7:0]];

    always @(posedge clk) begin
        if (precarga)
            mem[4] <= 32'h80FF7F01;
        else if (mem_escribir)
            mem[direccion[7:0]] <= dato_escribir;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, esp);
        end
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    task automatic cargar_palabra4();
        precarga = 1'b1;
        paso();
        precarga = 1'b0;
    endtask

    // Issues one request from IDLE and records per-cycle observations until hecho.
    task automatic acceso(input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] d);
        r_hecho_k = 0; r_leer_k = 0; r_escr_k = 0; r_nleer = 0; r_nescr = 0;
        r_dato = 32'hX; r_err = 1'bx; r_escr_dir = 32'h0; r_escr_dato = 32'h0;
        es_escritura = w; tamano = t; sin_signo = s; direccion_byte = a; dato_in = d;
        valido = 1'b1;
        paso();
        valido = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_leer) begin
                r_nleer++;
                if (r_leer_k == 0) r_leer_k = k;
            end
            if (mem_escribir) begin
                r_nescr++;
                if (r_escr_k == 0) begin
                    r_escr_k = k; r_escr_dir = direccion; r_escr_dato = dato_escribir;
                end
            end
            if (hecho) begin
                r_hecho_k = k; r_dato = dato_cargado; r_err = error_alineacion;
                break;
            end
            paso();
        end
        if (r_hecho_k == 0)
            comprobar("timeout_hecho", 32'd0, 32'd1);
        paso();
    endtask

    initial begin
        reset = 1'b1; valido = 1'b0; es_escritura = 1'b0; tamano = 2'b00;
        sin_signo = 1'b0; direccion_byte = 32'h0; dato_in = 32'h0; precarga = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        #12;
        comprobar("rst_listo", {31'h0, listo}, 32'd1);
        comprobar("rst_hecho", {31'h0, hecho}, 32'd0);
        comprobar("rst_enables", {30'h0, mem_leer, mem_escribir}, 32'd0);
        comprobar("rst_direccion", direccion, 32'h0);
        comprobar("rst_dato_cargado", dato_cargado, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        paso();

        // Loads
        cargar_palabra4();
        acceso(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        comprobar("lb_11_dato", r_dato, 32'h0000007F);
        comprobar("lb_11_ciclo", r_hecho_k, 2);
        comprobar("lb_11_leer_ciclo", r_leer_k, 1);
        comprobar("lb_11_err", {31'h0, r_err}, 32'd0);
        acceso(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        comprobar("lb_13_dato", r_dato, 32'hFFFFFF80);
        acceso(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        comprobar("lbu_13_dato", r_dato, 32'h00000080);
        acceso(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        comprobar("lh_12_dato", r_dato, 32'hFFFF80FF);
        acceso(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        comprobar("lhu_12_dato", r_dato, 32'h000080FF);
        acceso(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        comprobar("lw_10_dato", r_dato, 32'h80FF7F01);

        // sb read-modify-write
        cargar_palabra4();
        acceso(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
        comprobar("sb_leer_ciclo", r_leer_k, 1);
        comprobar("sb_escr_ciclo", r_escr_k, 2);
        comprobar("sb_escr_dir", r_escr_dir, 32'd4);
        comprobar("sb_escr_dato", r_escr_dato, 32'h80AB7F01);
        comprobar("sb_hecho_ciclo", r_hecho_k, 3);
        comprobar("sb_dato_cargado", r_dato, 32'h0);
        acceso(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        comprobar("sb_lw_dato", r_dato, 32'h80AB7F01);

        // sh into the low half
        cargar_palabra4();
        acceso(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
        comprobar("sh_escr_dato", r_escr_dato, 32'h80FF1234);
        comprobar("sh_hecho_ciclo", r_hecho_k, 3);

        // sw
        cargar_palabra4();
        acceso(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        comprobar("sw_nleer", r_nleer, 0);
        comprobar("sw_nescr", r_nescr, 1);
        comprobar("sw_escr_ciclo", r_escr_k, 1);
        comprobar("sw_hecho_ciclo", r_hecho_k, 2);
        acceso(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        comprobar("sw_lw_dato", r_dato, 32'hDEADBEEF);

        // Misaligned and reserved size
        cargar_palabra4();
        acceso(1'b1, 2'b10, 1'b0, 32'h13, 32'h12345678);
        comprobar("mis_sw_ciclo", r_hecho_k, 1);
        comprobar("mis_sw_err", {31'h0, r_err}, 32'd1);
        comprobar("mis_sw_enables", r_nleer + r_nescr, 0);
        comprobar("mis_sw_mem", mem[4], 32'h80FF7F01);
        acceso(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        comprobar("mis_lh_ciclo", r_hecho_k, 1);
        comprobar("mis_lh_err", {31'h0, r_err}, 32'd1);
        comprobar("mis_lh_dato", r_dato, 32'h0);
        comprobar("mis_lh_enables", r_nleer + r_nescr, 0);
        acceso(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        comprobar("mis_t11_ciclo", r_hecho_k, 1);
        comprobar("mis_t11_err", {31'h0, r_err}, 32'd1);
        comprobar("mis_t11_enables", r_nleer + r_nescr, 0);

        // Reset during ESCRIBIR of sb
        cargar_palabra4();
        es_escritura = 1'b1; tamano = 2'b00; sin_signo = 1'b0;
        direccion_byte = 32'h12; dato_in = 32'h000000AB; valido = 1'b1;
        paso();
        valido = 1'b0;
        comprobar("rstmid_leer", {31'h0, mem_leer}, 32'd1);
        paso();
        comprobar("rstmid_escr_antes", {31'h0, mem_escribir}, 32'd1);
        reset = 1'b1;
        #1;
        comprobar("rstmid_escr_cae", {31'h0, mem_escribir}, 32'd0);
        paso();
        comprobar("rstmid_mem", mem[4], 32'h80FF7F01);
        comprobar("rstmid_hecho", {31'h0, hecho}, 32'd0);
        comprobar("rstmid_listo", {31'h0, listo}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        paso();

        // Handshake: fields changed during LEER are ignored; valido held re-accepts after FIN
        cargar_palabra4();
        begin
            int          hk [2];
            logic [31:0] hd [2];
            int          nh;
            logic        listo_k3;
            nh = 0; hk[0] = 0; hk[1] = 0; hd[0] = 32'h0; hd[1] = 32'h0; listo_k3 = 1'b0;
            es_escritura = 1'b0; tamano = 2'b00; sin_signo = 1'b0;
            direccion_byte = 32'h11; valido = 1'b1;
            paso();
            es_escritura = 1'b0; tamano = 2'b10; direccion_byte = 32'h10;
            for (int k = 1; k <= 7; k++) begin
                if (k == 3) listo_k3 = listo;
                if (hecho && nh < 2) begin
                    hk[nh] = k; hd[nh] = dato_cargado; nh++;
                end
                paso();
            end
            valido = 1'b0;
            comprobar("hs_hecho1_ciclo", hk[0], 2);
            comprobar("hs_hecho1_dato", hd[0], 32'h0000007F);
            comprobar("hs_listo_k3", {31'h0, listo_k3}, 32'd1);
            comprobar("hs_hecho2_ciclo", hk[1], 5);
            comprobar("hs_hecho2_dato", hd[1], 32'h80FF7F01);
        end
        paso();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule
